// File: rtl/wb_inst_feeder.sv
// Wishbone instruction feeder: a FIFO of 32-bit words served to a core as reads,
// with core-write capture and a run-cycle budget that gates the core and the slave FSM.
module wb_inst_feeder #(
  parameter int          WB_DWIDTH    = 128,
  parameter int          DEPTH        = 16,
  parameter logic [31:0] NOP_WORD     = 32'hF0801003,
  parameter int          ACK_LATENCY  = 0,
  parameter int          ERR_ON_EMPTY = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_valid,
  input  logic [31:0]                push_data,
  output logic                       push_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  input  logic                       run_load,
  input  logic [15:0]                run_count,
  output logic                       core_en,
  input  logic [31:0]                o_wb_adr,
  input  logic [WB_DWIDTH/8-1:0]     o_wb_sel,
  input  logic                       o_wb_we,
  input  logic [WB_DWIDTH-1:0]       o_wb_dat,
  input  logic                       o_wb_cyc,
  input  logic                       o_wb_stb,
  output logic [WB_DWIDTH-1:0]       i_wb_dat,
  output logic                       i_wb_ack,
  output logic                       i_wb_err,
  output logic                       cap_valid,
  output logic [31:0]                cap_adr,
  output logic [WB_DWIDTH-1:0]       cap_dat,
  output logic [WB_DWIDTH/8-1:0]     cap_sel
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int LANES = WB_DWIDTH / 32;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  logic [31:0]          r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]        r_level;
  state_t               r_state, w_state_nxt;
  logic [2:0]           r_wait_cnt, w_wait_nxt;
  logic [15:0]          r_budget, w_budget_nxt;
  logic                 r_core_en;
  logic                 r_ack, r_err, r_cap_valid;
  logic [WB_DWIDTH-1:0] r_dat, r_cap_dat;
  logic [31:0]          r_cap_adr;
  logic [WB_DWIDTH/8-1:0] r_cap_sel;

  logic                 w_full, w_empty, w_push, w_pop;
  logic                 w_enter_ack, w_rd, w_wr, w_err_nxt;
  logic [WB_DWIDTH-1:0] w_nop_bus, w_rd_bus;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);

  // Run budget: a load always beats the per-cycle decrement.
  assign w_budget_nxt = run_load ? run_count :
                        (r_budget != 16'd0) ? r_budget - 16'd1 : r_budget;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_budget  <= '0;
      r_core_en <= 1'b0;
    end else begin
      r_budget  <= w_budget_nxt;
      r_core_en <= (w_budget_nxt != 16'd0);
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_enter_ack = 1'b0;
    if (r_core_en) begin
      case (r_state)
        S_IDLE: if (o_wb_cyc && o_wb_stb) begin
          if (ACK_LATENCY == 0) begin
            w_state_nxt = S_ACK;
            w_enter_ack = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_wait_nxt  = 3'(ACK_LATENCY - 1);
          end
        end
        S_WAIT: begin
          if (!o_wb_cyc) begin
            w_state_nxt = S_IDLE;
            w_wait_nxt  = '0;
          end else if (r_wait_cnt == 3'd0) begin
            w_state_nxt = S_ACK;
            w_enter_ack = 1'b1;
          end else begin
            w_wait_nxt = r_wait_cnt - 3'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // The response is registered on the edge into ACK, so it is visible for the ACK cycle.
  assign w_rd      = w_enter_ack && !o_wb_we;
  assign w_wr      = w_enter_ack &&  o_wb_we;
  assign w_pop     = w_rd && !w_empty;
  assign w_err_nxt = w_rd && w_empty && (ERR_ON_EMPTY != 0);
  // A push at full is taken only when the same cycle pops, keeping the level at DEPTH.
  assign w_push    = push_valid && (!w_full || w_pop);

  always_comb begin
    for (int l = 0; l < LANES; l++) w_nop_bus[l*32 +: 32] = NOP_WORD;
    w_rd_bus       = w_nop_bus;
    w_rd_bus[31:0] = r_mem[r_rd_ptr];
  end

  // NOTE: the storage array carries no reset; validity comes only from the pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_dat       <= w_nop_bus;
      r_cap_valid <= 1'b0;
      r_cap_adr   <= '0;
      r_cap_dat   <= '0;
      r_cap_sel   <= '0;
    end else if (r_core_en) begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_cap_valid <= 1'b0;
      if (w_rd) begin
        r_dat <= w_empty ? w_nop_bus : w_rd_bus;
        if (w_err_nxt) r_err <= 1'b1;
        else           r_ack <= 1'b1;
      end
      if (w_wr) begin
        r_ack       <= 1'b1;
        r_cap_valid <= 1'b1;
        r_cap_adr   <= o_wb_adr;
        r_cap_dat   <= o_wb_dat;
        r_cap_sel   <= o_wb_sel;
      end
    end
  end

  assign push_ready = !w_full;
  assign fifo_level = r_level;
  assign core_en    = r_core_en;
  assign i_wb_dat   = r_dat;
  assign i_wb_ack   = r_ack;
  assign i_wb_err   = r_err;
  assign cap_valid  = r_cap_valid;
  assign cap_adr    = r_cap_adr;
  assign cap_dat    = r_cap_dat;
  assign cap_sel    = r_cap_sel;

endmodule
